md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the five-stage pipeline: accepts a mult/multu/div/divu issue from the E stage, holds the HI/LO result registers, and reports busy to the hazard unit so that later HI/LO-dependent instructions stall in D. It also services mthi/mtlo writes and drives HI/LO for mfhi/mflo forwarding into the E-stage result mux.

---
 rtl/md_sequencer.sv | 161 ++++++++++++++++
 tb/tb_md_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/multu/div/divu unit owning the HI/LO registers.
// Optional abort port and flush behaviour are enabled by defining MD_ABORT_EN.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        md_hold,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        res_wr_q, res_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;
  logic        abort_w;

`ifdef MD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Result datapath: evaluated in the issue cycle and parked in res_q until completion.
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo, rem;
  logic [63:0] ext_a, ext_b, prod;
  logic [63:0] calc_res;
  logic        calc_wr;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & src_a[31];
    b_neg     = is_signed & src_b[31];
    // Sign-extending to 64 bits makes the low half of one unsigned product
    // correct for both the signed and unsigned multiply.
    ext_a     = {{32{a_neg}}, src_a};
    ext_b     = {{32{b_neg}}, src_b};
    prod      = ext_a * ext_b;

    mag_a     = a_neg ? (~src_a + 32'd1) : src_a;
    mag_b     = b_neg ? (~src_b + 32'd1) : src_b;
    quo_mag   = '0;
    rem_mag   = '0;
    if (src_b != '0) begin
      quo_mag = mag_a / mag_b;
      rem_mag = mag_a % mag_b;
    end
    // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
    quo       = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    rem       = a_neg ? (~rem_mag + 32'd1) : rem_mag;

    calc_res  = op[1] ? {rem, quo} : prod;
    calc_wr   = ~(op[1] & (src_b == '0));
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_wr_d = res_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!abort_w) begin
            res_d    = calc_res;
            res_wr_d = calc_wr;
            cnt_d    = op[1] ? DIV_LOAD : MULT_LOAD;
            state_d  = op[1] ? ST_DIV : ST_MUL;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      ST_MUL, ST_DIV: begin
        if (start || hi_we || lo_we) err_d = 1'b1;
        if (abort_w) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          if (res_wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      res_wr_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_wr_q <= res_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign md_hold = busy | start;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign err     = err_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: a reference model predicts HI/LO/err and busy length per op.
// Abort scenarios run only when MD_ABORT_EN is defined.
module tb_md_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
`ifdef MD_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy, md_hold, err;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
`ifdef MD_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .md_hold (md_hold),
    .hi      (hi),
    .lo      (lo),
    .err     (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural reference: plain 64-bit arithmetic, C-style truncating division.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1'b1;
    rh = '0;
    rl = '0;
    case (o)
      2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      2'd2: begin
        if (b == 0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
      end
      default: begin
        if (b == 0) wr = 1'b0;
        else begin up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0]; end
      end
    endcase
  endfunction

  // Issue one op from idle. abort_at>0 aborts at that busy edge; mthi_at>0 fires mthi then.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int intf_pct, input int abort_at, input int mthi_at);
    logic [31:0] rh, rl;
    bit          wr;
    int          n;
    exp_t        e;
    bit          intf[16];
    n = o[1] ? DC : MC;
    ref_op(o, a, b, rh, rl, wr);
    for (int k = 0; k < 16; k++) begin
      intf[k] = (k < n) && ($urandom_range(99) < intf_pct);
      if (k == mthi_at - 1) intf[k] = 1'b1;
      if (intf[k]) m_err = 1'b1;
    end
    if (abort_at == 0) begin
      if (wr) begin m_hi = rh; m_lo = rl; end
      e.cycles = n;
    end else begin
      e.cycles = abort_at;
    end
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.err = m_err;
    sb_q.push_back(e);

    check("busy_before_start", {63'd0, busy}, 64'd0);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    check("md_hold_on_start", {63'd0, md_hold}, 64'd1);
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int k = 0; k < n; k++) begin
`ifdef MD_ABORT_EN
      if (k == abort_at - 1) abort = 1'b1;
`endif
      if (k == mthi_at - 1) begin
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else if (intf[k]) begin
        case ($urandom_range(2))
          0:       begin hi_we = 1'b1; wdata = $urandom; end
          1:       begin lo_we = 1'b1; wdata = $urandom; end
          default: begin start = 1'b1; op = 2'($urandom_range(3)); src_a = $urandom; src_b = $urandom; end
        endcase
      end
      tick();
      hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
`ifdef MD_ABORT_EN
      abort = 1'b0;
`endif
      if (k == abort_at - 1) break;
    end
  endtask

  task automatic idle_write(input bit wh, input bit wl, input logic [31:0] d);
    hi_we = wh; lo_we = wl; wdata = d;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("idle_hi", {32'd0, hi}, {32'd0, m_hi});
    check("idle_lo", {32'd0, lo}, {32'd0, m_lo});
    check("idle_err", {63'd0, err}, {63'd0, m_err});
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: each busy fall is one completed/cancelled op; compare against the scoreboard.
  initial begin : monitor
    bit   prev;
    int   cyc;
    exp_t e;
    prev = 1'b0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!prev) cyc = 0;
        cyc++;
      end else if (prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: busy fell with no op pending (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("op_busy_cycles", 64'(cyc), 64'(e.cycles));
          check("op_hi", {32'd0, hi}, {32'd0, e.hi});
          check("op_lo", {32'd0, lo}, {32'd0, e.lo});
          check("op_err", {63'd0, err}, {63'd0, e.err});
        end
      end
      prev = (busy === 1'b1);
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    #2 reset = 1'b0;
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_md_hold", {63'd0, md_hold}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);

    do_op(2'd0, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
    check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);
    do_op(2'd1, 32'hFFFF_FFFE, 32'h3, 0, 0, 0);
    check("multu_hi", {32'd0, hi}, 64'h2);
    check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFA);
    do_op(2'd2, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
    check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    idle_write(1'b1, 1'b0, 32'h11);
    idle_write(1'b0, 1'b1, 32'h22);
    do_op(2'd3, 32'h7, 32'h0, 0, 0, 0);
    check("divz_hi", {32'd0, hi}, 64'h11);
    check("divz_lo", {32'd0, lo}, 64'h22);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    check("ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("ovf_hi", {32'd0, hi}, 64'h0);
    // Back-to-back issue with an mthi during busy.
    do_op(2'd0, 32'h3, 32'h4, 0, 0, 2);
    check("busy_mthi_hi", {32'd0, hi}, 64'h0);
    check("busy_mthi_err", {63'd0, err}, 64'd1);
    idle_write(1'b0, 1'b1, 32'h1234);
    check("mtlo_lo", {32'd0, lo}, 64'h1234);
    // Start together with mthi/mtlo: start wins.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    do_op(2'd1, 32'h9, 32'h9, 0, 0, 0);
    check("start_wins_lo", {32'd0, lo}, 64'd81);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0)
        idle_write(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
      do_op(2'($urandom_range(3)), pick($urandom_range(7)), pick($urandom_range(7)), 4, 0, 0);
    end

    // Reset in the third busy cycle of a div.
    e.hi = '0; e.lo = '0; e.cycles = 2; e.err = 1'b0;
    sb_q.push_back(e);
    op = 2'd2; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_err = 1'b0;
    #1;
    check("rstkill_busy", {63'd0, busy}, 64'd0);
    check("rstkill_hi", {32'd0, hi}, 64'd0);
    check("rstkill_lo", {32'd0, lo}, 64'd0);
    check("rstkill_err", {63'd0, err}, 64'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (DC + 2) tick();
    check("rstkill_late_busy", {63'd0, busy}, 64'd0);
    check("rstkill_late_hi", {32'd0, hi}, 64'd0);
    check("rstkill_late_lo", {32'd0, lo}, 64'd0);

`ifdef MD_ABORT_EN
    idle_write(1'b1, 1'b0, 32'h5);
    idle_write(1'b0, 1'b1, 32'h6);
    do_op(2'd0, 32'h7, 32'h9, 0, 2, 0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'h5);
    check("abort_lo", {32'd0, lo}, 64'h6);
    do_op(2'd1, 32'h7, 32'h9, 0, MC, 0);
    check("abort_end_hi", {32'd0, hi}, 64'h5);
    check("abort_end_lo", {32'd0, lo}, 64'h6);
    abort = 1'b1; start = 1'b1; op = 2'd0; src_a = 32'h3; src_b = 32'h3;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    check("abort_idle_hi", {32'd0, hi}, 64'h5);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
